// File: rtl/mem_ctrl_if.sv
// Request/grant and MAR/MDR/RAM strobe bundle between the control unit, mem_ctrl and the memory group.
// Handshake: a requester raises *_req with its address and keeps req up until it sees the one-cycle *_gnt; dropping req earlier is a withdrawal.
interface mem_ctrl_if #(
    parameter int AW = 9
);
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          data_req;
    logic          data_we;
    logic [AW-1:0] data_addr;
    logic          fetch_gnt;
    logic          data_gnt;
    logic          done;
    logic          done_id;
    logic          err;
    logic          busy;
    logic [AW-1:0] mar_addr;
    logic          mar_en;
    logic          mdr_read;
    logic          mdr_en;
    logic          mem_rd;
    logic          mem_wr;
    logic          mem_ready;

    modport slave (
        input  fetch_req, fetch_addr, data_req, data_we, data_addr, mem_ready,
        output fetch_gnt, data_gnt, done, done_id, err, busy,
               mar_addr, mar_en, mdr_read, mdr_en, mem_rd, mem_wr
    );

    modport master (
        output fetch_req, fetch_addr, data_req, data_we, data_addr, mem_ready,
        input  fetch_gnt, data_gnt, done, done_id, err, busy,
               mar_addr, mar_en, mdr_read, mdr_en, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Round-robin fetch/data arbiter and MAR/RAM/MDR access sequencer (IDLE -> ADDR -> ACCESS -> DONE).
// Optional access timeout is compiled in with MEM_CTRL_TIMEOUT_EN.
module mem_ctrl #(
    parameter int AW      = 9,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        clear,
    mem_ctrl_if.slave   bus,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_ctrl: TIMEOUT must be in 1..255");
    end

    state_t        state;
    logic          last_id;
    logic          lat_id;
    logic          lat_we;
    logic [AW-1:0] mar_addr_q;
    logic          fetch_gnt_q;
    logic          data_gnt_q;
    logic          mar_en_q;
    logic          done_q;
    logic          done_id_q;
    logic          err_q;
    logic          busy_q;
    logic          mem_rd_q;
    logic          mem_wr_q;
    logic          mdr_read_q;

    logic          any_req;
    logic          pick_id;
    logic          timed_out;

    // Tie goes to the requester that did not win last time; last_id resets to data so fetch wins first.
    always_comb begin
        any_req = bus.fetch_req | bus.data_req;
        pick_id = 1'b0;
        if (bus.fetch_req && bus.data_req) begin
            pick_id = ~last_id;
        end else begin
            pick_id = bus.data_req;
        end
    end

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    logic [7:0] wait_cnt;
    assign timed_out = !bus.mem_ready && ((wait_cnt + 8'd1) == TIMEOUT_CNT);
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state       <= IDLE;
            last_id     <= 1'b1;
            lat_id      <= 1'b0;
            lat_we      <= 1'b0;
            mar_addr_q  <= '0;
            fetch_gnt_q <= 1'b0;
            data_gnt_q  <= 1'b0;
            mar_en_q    <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mdr_read_q  <= 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
            wait_cnt    <= 8'd0;
`endif
        end else begin
            fetch_gnt_q <= 1'b0;
            data_gnt_q  <= 1'b0;
            mar_en_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            case (state)
                // DONE accepts like IDLE so a waiting request issues back-to-back.
                IDLE, DONE: begin
                    if (any_req) begin
                        state       <= ADDR;
                        busy_q      <= 1'b1;
                        lat_id      <= pick_id;
                        last_id     <= pick_id;
                        lat_we      <= pick_id & bus.data_we;
                        mar_addr_q  <= pick_id ? bus.data_addr : bus.fetch_addr;
                        mar_en_q    <= 1'b1;
                        fetch_gnt_q <= ~pick_id;
                        data_gnt_q  <= pick_id;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                ADDR: begin
                    state      <= ACCESS;
                    mem_rd_q   <= ~lat_we;
                    mem_wr_q   <= lat_we;
                    mdr_read_q <= ~lat_we;
`ifdef MEM_CTRL_TIMEOUT_EN
                    wait_cnt   <= 8'd0;
`endif
                end
                ACCESS: begin
                    if (bus.mem_ready || timed_out) begin
                        state      <= DONE;
                        mem_rd_q   <= 1'b0;
                        mem_wr_q   <= 1'b0;
                        mdr_read_q <= 1'b0;
                        done_q     <= 1'b1;
                        done_id_q  <= lat_id;
                        err_q      <= timed_out;
                    end
`ifdef MEM_CTRL_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fetch_gnt = fetch_gnt_q;
    assign bus.data_gnt  = data_gnt_q;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.mar_addr  = mar_addr_q;
    assign bus.mar_en    = mar_en_q;
    assign bus.mdr_read  = mdr_read_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    // Only combinational path from an input: the MDR loads on the same edge memory reports ready.
    assign bus.mdr_en    = mdr_read_q & bus.mem_ready;
    assign state_dbg     = state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-timeline model (grant, access window, done cycle) checked every cycle.
module tb_mem_ctrl;
    localparam int AW  = 9;
    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       clear;
    logic [1:0] state_dbg;

    mem_ctrl_if #(.AW(AW)) bus();

    mem_ctrl #(.AW(AW), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .clear     (clear),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int total;
    int bad;

    // Model: each accepted access is a timeline of grant cycle, access window and done cycle.
    int            cyc;
    bit            m_act;
    int            m_ac;
    int            m_dc;
    int            m_w;
    bit            m_id;
    bit            m_we;
    bit            m_err;
    bit            m_last;
    logic [AW-1:0] m_mar;
    logic [AW:0]   exp_q[$];

    int force_w;
    int req_mode;

    logic [31:0] ram [0:(1<<AW)-1];
    logic [31:0] mdr_q;
    bit          cap_pend;
    logic [31:0] cap_data;

    int wr_cycles;
    int mdr_en_cnt;
    int done_cnt;
    int err_cnt;
    int gnt_id_log[$];
    int gnt_cyc_log[$];
    int done_cyc_log[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic reset_model();
        m_act    = 0;
        m_last   = 1;
        m_mar    = '0;
        cap_pend = 0;
        exp_q.delete();
    endtask

    task automatic clear_logs();
        wr_cycles  = 0;
        mdr_en_cnt = 0;
        done_cnt   = 0;
        err_cnt    = 0;
        gnt_id_log.delete();
        gnt_cyc_log.delete();
        done_cyc_log.delete();
    endtask

    task automatic model_edge();
        int prev;
        bit id;
        prev = cyc;
        if (cap_pend) mdr_q = cap_data;
        cap_pend = 0;
        if (!m_act || prev == m_dc) begin
            m_act = 0;
            if (bus.fetch_req || bus.data_req) begin
                if (bus.fetch_req && bus.data_req) id = !m_last;
                else id = bus.data_req;
                m_last = id;
                m_id   = id;
                m_we   = id ? bus.data_we : 1'b0;
                m_mar  = id ? bus.data_addr : bus.fetch_addr;
                m_ac   = prev + 1;
                if (force_w >= 0) m_w = force_w;
                else if ($urandom_range(0, 7) == 0) m_w = int'($urandom_range(4, 6));
                else m_w = int'($urandom_range(0, 3));
                m_err = 0;
                m_dc  = m_ac + 2 + m_w;
`ifdef MEM_CTRL_TIMEOUT_EN
                if (m_w >= TMO) begin
                    m_err = 1;
                    m_dc  = m_ac + 1 + TMO;
                end
`endif
                m_act = 1;
                exp_q.push_back({id, m_mar});
            end
        end
        cyc = prev + 1;
    endtask

    task automatic drive();
        bit in_acc;
        in_acc = m_act && cyc > m_ac && cyc < m_dc;
        if (in_acc) bus.mem_ready = ((cyc - m_ac - 1) == m_w);
        else bus.mem_ready = 1'($urandom_range(0, 1));
        case (req_mode)
            0: begin
                if (bus.fetch_req && bus.fetch_gnt) bus.fetch_req = 1'b0;
                if (bus.data_req && bus.data_gnt) bus.data_req = 1'b0;
            end
            2: begin
                if (bus.fetch_req && bus.fetch_gnt) bus.fetch_req = ($urandom_range(0, 3) == 0);
                else if (bus.fetch_req) begin
                    if ($urandom_range(0, 15) == 0) bus.fetch_req = 1'b0;
                end else bus.fetch_req = ($urandom_range(0, 2) == 0);
                if (bus.data_req && bus.data_gnt) bus.data_req = ($urandom_range(0, 3) == 0);
                else if (bus.data_req) begin
                    if ($urandom_range(0, 15) == 0) bus.data_req = 1'b0;
                end else bus.data_req = ($urandom_range(0, 2) == 0);
                bus.fetch_addr = AW'($urandom_range(0, (1 << AW) - 1));
                bus.data_addr  = AW'($urandom_range(0, (1 << AW) - 1));
                bus.data_we    = 1'($urandom_range(0, 1));
            end
            default: ;
        endcase
    endtask

    task automatic check_cycle();
        bit eg;
        bit ea;
        bit ed;
        logic [AW:0] e;
        eg = m_act && cyc == m_ac;
        ea = m_act && cyc > m_ac && cyc < m_dc;
        ed = m_act && cyc == m_dc;
        chk("fetch_gnt", bus.fetch_gnt, eg && !m_id);
        chk("data_gnt", bus.data_gnt, eg && m_id);
        chk("mar_en", bus.mar_en, eg);
        chk("mar_addr", bus.mar_addr, m_mar);
        chk("busy", bus.busy, m_act);
        chk("mem_rd", bus.mem_rd, ea && !m_we);
        chk("mem_wr", bus.mem_wr, ea && m_we);
        chk("mdr_read", bus.mdr_read, ea && !m_we);
        chk("mdr_en", bus.mdr_en, ea && !m_we && bus.mem_ready);
        chk("done", bus.done, ed);
        chk("err", bus.err, ed && m_err);
        if (ed) chk("done_id", bus.done_id, m_id);
        if (bus.fetch_gnt || bus.data_gnt) begin
            if (exp_q.size() == 0) chk("gnt_unexpected", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                chk("sb_gnt", {bus.data_gnt, bus.mar_addr}, e);
            end
            gnt_id_log.push_back(bus.data_gnt ? 1 : 0);
            gnt_cyc_log.push_back(cyc);
        end
        if (bus.mdr_en) begin
            cap_pend = 1;
            cap_data = ram[bus.mar_addr];
        end
        wr_cycles  += bus.mem_wr;
        mdr_en_cnt += bus.mdr_en;
        err_cnt    += bus.err;
        if (bus.done) begin
            done_cnt++;
            done_cyc_log.push_back(cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        drive();
        #1 check_cycle();
    endtask

    // Asynchronous clear in the low phase; outputs must drop before the next edge.
    task automatic pulse_clear(input string tag);
        #3 clear = 1'b0;
        bus.fetch_req = 1'b0;
        bus.data_req  = 1'b0;
        #1;
        reset_model();
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_mem_rd"}, bus.mem_rd, 0);
        chk({tag, "_done"}, bus.done, 0);
        check_cycle();
        @(posedge clk);
        @(negedge clk);
        #2 clear = 1'b1;
    endtask

    initial begin
        logic [31:0] mdr_before;
        total = 0;
        bad   = 0;
        cyc   = 0;
        force_w  = -1;
        req_mode = 0;
        mdr_q    = '0;
        cap_data = '0;
        reset_model();
        clear_logs();
        for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.data_req   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_addr  = '0;
        bus.mem_ready  = 1'b0;
        clear = 1'b1;
        #2 clear = 1'b0;
        #1;
        chk("rst_fetch_gnt", bus.fetch_gnt, 0);
        chk("rst_data_gnt", bus.data_gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_done_id", bus.done_id, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mar_addr", bus.mar_addr, 0);
        chk("rst_mar_en", bus.mar_en, 0);
        chk("rst_mdr_read", bus.mdr_read, 0);
        chk("rst_mdr_en", bus.mdr_en, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_state", state_dbg, 0);
        @(negedge clk);
        #2 clear = 1'b1;

        // Zero-wait fetch read of 0x012.
        ram[9'h012]    = 32'hDEADBEEF;
        bus.fetch_addr = 9'h012;
        bus.fetch_req  = 1'b1;
        force_w = 0;
        step();
        chk("t1_fetch_gnt", bus.fetch_gnt, 1);
        chk("t1_mar_en", bus.mar_en, 1);
        chk("t1_mar_addr", bus.mar_addr, 9'h012);
        step();
        chk("t1_mem_rd", bus.mem_rd, 1);
        chk("t1_mdr_en", bus.mdr_en, 1);
        step();
        chk("t1_done", bus.done, 1);
        chk("t1_done_id", bus.done_id, 0);
        step();
        chk("t1_mdr", mdr_q, 32'hDEADBEEF);

        // Data write to 0x1F0 with four wait cycles.
        clear_logs();
        bus.data_addr = 9'h1F0;
        bus.data_we   = 1'b1;
        bus.data_req  = 1'b1;
        force_w = 4;
        repeat (9) step();
        chk("t2_wr_cycles", wr_cycles, 5);
        chk("t2_mdr_en_cnt", mdr_en_cnt, 0);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_gnt_id", (gnt_id_log.size() == 1) ? gnt_id_log[0] : -1, 1);
        chk("t2_gnt_to_done",
            (gnt_cyc_log.size() > 0 && done_cyc_log.size() > 0) ? done_cyc_log[0] - gnt_cyc_log[0] : -1, 6);
        bus.data_we = 1'b0;

        // Both requesters held: alternate every 3 cycles, no IDLE gap.
        clear_logs();
        force_w  = 0;
        req_mode = 1;
        bus.fetch_req = 1'b1;
        bus.data_req  = 1'b1;
        repeat (12) step();
        chk("t3_gnt_count", gnt_id_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_gnt_id%0d", i), (gnt_id_log.size() > i) ? gnt_id_log[i] : -1, i % 2);
            if (i > 0)
                chk($sformatf("t3_gnt_gap%0d", i),
                    (gnt_cyc_log.size() > i) ? gnt_cyc_log[i] - gnt_cyc_log[i-1] : -1, 3);
        end
        req_mode = 0;
        bus.fetch_req = 1'b0;
        bus.data_req  = 1'b0;
        repeat (4) step();

        // Clear during a fetch read's ACCESS; then a tie must go to fetch again.
        force_w = 3;
        bus.fetch_addr = 9'h055;
        bus.fetch_req  = 1'b1;
        step();
        step();
        chk("t4_pre_mem_rd", bus.mem_rd, 1);
        pulse_clear("t4_clr");
        clear_logs();
        repeat (4) step();
        chk("t4_no_done", done_cnt, 0);
        force_w = 0;
        bus.fetch_addr = 9'h0A0;
        bus.data_addr  = 9'h0B0;
        bus.fetch_req  = 1'b1;
        bus.data_req   = 1'b1;
        step();
        chk("t4_tie_fetch", bus.fetch_gnt, 1);
        chk("t4_tie_data", bus.data_gnt, 0);
        repeat (8) step();

        // Memory never ready.
        clear_logs();
        mdr_before = mdr_q;
        force_w = 100000;
        bus.fetch_addr = 9'h077;
        bus.fetch_req  = 1'b1;
        repeat (102) step();
`ifdef MEM_CTRL_TIMEOUT_EN
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_err_cnt", err_cnt, 1);
        chk("t5_to_cycles",
            (gnt_cyc_log.size() > 0 && done_cyc_log.size() > 0) ? done_cyc_log[0] - gnt_cyc_log[0] : -1, TMO + 1);
`else
        chk("t5_busy", bus.busy, 1);
        chk("t5_mem_rd", bus.mem_rd, 1);
        chk("t5_done_cnt", done_cnt, 0);
`endif
        chk("t5_mdr_en_cnt", mdr_en_cnt, 0);
        chk("t5_mdr_same", mdr_q, mdr_before);
        pulse_clear("t5_clr");

        // Randomized traffic.
        force_w  = -1;
        req_mode = 2;
        repeat (3000) step();
        req_mode = 0;
        bus.fetch_req = 1'b0;
        bus.data_req  = 1'b0;
        repeat (12) step();
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory access sequencer and two-port arbiter for the CPU datapath. It accepts read/write requests from the instruction-fetch path and the data (load/store) path and grants them round-robin. For each granted request it sequences MAR load, the memory read/write strobes and the MDR capture, driving the MDR input-select and enable lines so memory data lands in the MDR. It sits between the control unit and the MAR/MDR/RAM group.

## Interface
Parameters:
- AW, 9, address width (MAR / RAM address).
- TIMEOUT, 15, maximum ACCESS cycles without mem_ready; used only when the timeout feature is compiled in; range 1..255.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch requester wants a read.
- fetch_addr  in  AW  fetch address; sampled when the request is accepted.
- data_req  in  1  data requester wants an access.
- data_we  in  1  1 = write (MDR to memory), 0 = read; sampled with data_addr.
- data_addr  in  AW  data address.
- fetch_gnt  out  1  one-cycle pulse: fetch request accepted.
- data_gnt  out  1  one-cycle pulse: data request accepted.
- done  out  1  one-cycle pulse: access complete.
- done_id  out  1  owner of the completing access: 0 = fetch, 1 = data; valid while done = 1.
- err  out  1  one-cycle pulse coincident with done; the access timed out.
- busy  out  1  high in every state except IDLE.
- mar_addr  out  AW  latched address to the MAR.
- mar_en  out  1  MAR load enable.
- mdr_read  out  1  MDR mux select: 1 = memory data in, 0 = bus.
- mdr_en  out  1  MDR load enable.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_ready  in  1  memory completes the current access this cycle.

## Operation
- States: IDLE, ADDR, ACCESS, DONE. Reset state is IDLE.
- Acceptance is evaluated in IDLE and in DONE, which gives back-to-back issue:
  - If any request is present, latch addr, we (fetch forces we = 0) and id, then go to ADDR.
  - Otherwise go to IDLE.
- Arbitration:
  - Only one request present: grant it.
  - Both present: grant the id opposite last_id.
  - last_id updates on acceptance; it resets to 1, so fetch wins the first tie.
- ADDR (one cycle):
  - The matching gnt = 1, mar_en = 1, mar_addr = latched address.
  - Next state is ACCESS.
- ACCESS:
  - mem_rd = !we and mem_wr = we, held for the whole state.
  - Read: mdr_read = 1, and mdr_en = mem_ready (combinational), so the MDR captures memory data on the edge where mem_ready = 1.
  - Write: mdr_read = 0, mdr_en = 0; the datapath must load the MDR before requesting.
  - mem_ready = 1 moves the FSM to DONE.
- DONE (one cycle): done = 1 and done_id = latched id.
- mar_addr holds its last latched value in all states.
- A requester holds req until it sees gnt. Dropping req before gnt is a withdrawal, with no side effects.
- Addresses and data_we are not required to be stable after gnt.
- The reset value of every output is 0: gnt, done, done_id, err, busy, mar_addr, mar_en, mdr_read, mdr_en, mem_rd, mem_wr.
- Asserting clear mid-access forces IDLE immediately and drops all strobes asynchronously. The in-flight access is lost and no done is issued.

## Timing
- Request seen at edge E:
  - gnt and mar_en are high in cycle E..E+1.
  - The strobe starts in cycle E+1..E+2.
- Zero-wait access (mem_ready = 1 in the first ACCESS cycle): done is high in the third cycle after acceptance, so request-to-done is 3 cycles.
- Each cycle with mem_ready = 0 adds one cycle.
- Back-to-back: a new request accepted at the end of DONE enters ADDR with no IDLE cycle, giving 3-cycle throughput at zero wait.
- mdr_en is the only combinational output from an input (mem_ready). All other outputs are decoded from registered state and latches.

## Configuration
- MEM_CTRL_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with mem_ready = 0.
  - When the count reaches TIMEOUT, the FSM goes to DONE with err = 1. mdr_en is not asserted and the strobes drop.
- MEM_CTRL_TIMEOUT_EN undefined: the counter is absent, ACCESS waits indefinitely, and err is tied to 0.

## Test plan
- Reset, then fetch_req = 1, fetch_addr = 0x012, RAM returns 0xDEADBEEF with mem_ready on the first ACCESS cycle -> fetch_gnt in cycle 1, mar_addr = 0x012, mem_rd in cycle 2, MDR = 0xDEADBEEF, done with done_id = 0 in cycle 3.
- data_we = 1, data_addr = 0x1F0, mem_ready delayed 4 cycles -> mem_wr held 5 cycles, mdr_en never high, done with done_id = 1 six cycles after gnt.
- fetch_req and data_req held high continuously -> grants alternate fetch, data, fetch, data, one every 3 cycles, with no IDLE cycle between accesses.
- clear pulsed low during ACCESS of a read -> mem_rd and busy fall immediately, no done, and the next request is accepted normally with fetch winning a tie.
- With MEM_CTRL_TIMEOUT_EN defined and TIMEOUT = 15, mem_ready held at 0 -> done and err both pulse after 15 ACCESS cycles and the MDR is unchanged. Without the macro, the FSM is still in ACCESS after 100 cycles.
